dk_walk_sound: RTL and testbench



---
 rtl/dk_walk_pkg.sv | 19 +
 rtl/dk_walk_slew.sv | 36 +++
 rtl/dk_walk_sound.sv | 104 ++++++++++
 tb/tb_dk_walk_sound.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/dk_walk_pkg.sv
// Shared constants and helpers for the Donkey Kong walk-sound synthesizer.
package dk_walk_pkg;

  localparam int F_START_HZ  = 800;
  localparam int F_END_HZ    = 200;
  localparam int DECAY_SHIFT = 9;
  localparam int SWEEP_SHIFT = 6;
  localparam int AMP         = 16384;
  localparam int ENV_MAX     = 32767;
  localparam int PHASE_W     = 24;

  // Rounded phase increment for a tone of hz at the given sample rate.
  function automatic longint hz_to_inc(input longint hz, input longint sample_rate);
    longint full_scale;
    full_scale = longint'(1) << PHASE_W;
    return (hz * full_scale + sample_rate / 2) / sample_rate;
  endfunction

endpackage

// File: rtl/dk_walk_slew.sv
// Exponential slew toward TARGET by (value - TARGET) >> SHIFT per update,
// with a load input that jumps straight to load_value. Exposes the
// post-update value combinationally so the caller can use it in the same edge.
module dk_walk_slew
  import dk_walk_pkg::*;
#(
  parameter int           W      = 16,
  parameter int           SHIFT  = DECAY_SHIFT,
  parameter logic [W-1:0] TARGET = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         update,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic [W-1:0] level
);

  logic [W-1:0] value_reg;
  logic [W-1:0] step;

  // Next value: load, slew toward the target, or hold; never slews past the target.
  always_comb begin
    step  = '0;
    if (value_reg > TARGET) step = (value_reg - TARGET) >> SHIFT;
    level = value_reg;
    if (update) level = load ? load_value : value_reg - step;
  end

  // State register, cleared by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) value_reg <= '0;
    else       value_reg <= level;
  end

endmodule

// File: rtl/dk_walk_sound.sv
// Donkey Kong walk sound: swept-pitch square oscillator with a decaying
// envelope, retriggered by rising edges of walk_en, one sample per audio_clk_en.
// Optional build macro DK_WALK_LPF_EN adds a one-pole low-pass on the output.
module dk_walk_sound
  import dk_walk_pkg::*;
#(
  parameter int CLOCK_RATE  = 48_000_000,
  parameter int SAMPLE_RATE = 48000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               audio_clk_en,
  input  logic               walk_en,
  output logic signed [15:0] out
);

  localparam logic [PHASE_W-1:0] INC_START = PHASE_W'(hz_to_inc(F_START_HZ, SAMPLE_RATE));
  localparam logic [PHASE_W-1:0] INC_END   = PHASE_W'(hz_to_inc(F_END_HZ, SAMPLE_RATE));
  localparam logic signed [15:0] SQ_POS    = 16'(AMP);
  localparam logic signed [15:0] SQ_NEG    = -16'(AMP);

  if (CLOCK_RATE / SAMPLE_RATE < 2) begin : g_rate_check
    $error("dk_walk_sound: CLOCK_RATE must be at least twice SAMPLE_RATE");
  end

  logic               walk_reg;
  logic               pending_reg;
  logic [15:0]        env_next;
  logic [PHASE_W-1:0] inc_next;
  logic [PHASE_W-1:0] phase_reg;
  logic [PHASE_W-1:0] phase_next;
  logic signed [15:0] sq;
  logic signed [32:0] mult;
  logic signed [15:0] prod;
  logic signed [15:0] out_next;
  logic               unused_mult_bits;

  // Trigger: register walk_en and latch rising edges until the next update consumes them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      walk_reg    <= 1'b0;
      pending_reg <= 1'b0;
    end else begin
      walk_reg    <= walk_en;
      pending_reg <= (pending_reg & ~audio_clk_en) | (walk_en & ~walk_reg);
    end
  end

  dk_walk_slew #(.W(16), .SHIFT(DECAY_SHIFT), .TARGET(16'd0)) u_env (
    .clk       (clk),
    .reset     (reset),
    .update    (audio_clk_en),
    .load      (pending_reg),
    .load_value(16'(ENV_MAX)),
    .level     (env_next)
  );

  dk_walk_slew #(.W(PHASE_W), .SHIFT(SWEEP_SHIFT), .TARGET(INC_END)) u_inc (
    .clk       (clk),
    .reset     (reset),
    .update    (audio_clk_en),
    .load      (pending_reg),
    .load_value(INC_START),
    .level     (inc_next)
  );

  // Phase accumulator restart/advance and the envelope-scaled square wave.
  always_comb begin
    phase_next = phase_reg;
    if (audio_clk_en) phase_next = pending_reg ? '0 : phase_reg + inc_next;
    sq   = phase_next[PHASE_W-1] ? SQ_NEG : SQ_POS;
    mult = sq * $signed({1'b0, env_next});
    prod = mult[30:15];
  end
  assign unused_mult_bits = ^{mult[32:31], mult[14:0]};

`ifdef DK_WALK_LPF_EN
  logic signed [17:0] lpf_diff;
  logic signed [17:0] lpf_acc;

  // One-pole low-pass in 18-bit arithmetic, saturated back to 16 bits.
  always_comb begin
    lpf_diff = {{2{prod[15]}}, prod} - {{2{out[15]}}, out};
    lpf_acc  = {{2{out[15]}}, out} + (lpf_diff >>> 3);
    if (lpf_acc > 18'sd32767)       out_next = 16'sh7fff;
    else if (lpf_acc < -18'sd32768) out_next = 16'sh8000;
    else                            out_next = lpf_acc[15:0];
  end
`else
  assign out_next = prod;
`endif

  // Phase and output registers advance only on a sample strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_reg <= '0;
      out       <= '0;
    end else if (audio_clk_en) begin
      phase_reg <= phase_next;
      out       <= out_next;
    end
  end

endmodule

// File: tb/tb_dk_walk_sound.sv
// Self-checking bench for dk_walk_sound (LPF off): a reference model pushes the
// expected sample on every strobe, the stimulus sequence pops and compares.
module tb_dk_walk_sound;

  localparam int INC_START = 279620;
  localparam int INC_END   = 69905;
  localparam int GAP       = 4;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               audio_clk_en = 1'b0;
  logic               walk_en = 1'b0;
  logic signed [15:0] out;

  int n_checks = 0;
  int n_errors = 0;

  logic signed [15:0] sb[$];

  // Reference model state
  int          m_env;
  longint      m_inc;
  logic [23:0] m_phase;
  logic        m_walk;
  logic        m_pending;

  dk_walk_sound #(.CLOCK_RATE(1_000_000), .SAMPLE_RATE(48000)) dut (
    .clk         (clk),
    .reset       (reset),
    .audio_clk_en(audio_clk_en),
    .walk_en     (walk_en),
    .out         (out)
  );

  always #5 clk = ~clk;

  function automatic logic signed [15:0] model_sample(input int env, input logic neg);
    int v;
    v = neg ? -((env + 1) / 2) : (env / 2);
    return 16'(v);
  endfunction

  // Reference model, advanced on the same edges as the DUT.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_env = 0; m_inc = 0; m_phase = '0; m_walk = 1'b0; m_pending = 1'b0;
      sb.delete();
    end else begin
      if (audio_clk_en) begin
        if (m_pending) begin
          m_env = 32767; m_inc = INC_START; m_phase = '0;
        end else begin
          m_env = m_env - (m_env / 512);
          if (m_inc > INC_END) m_inc = m_inc - ((m_inc - INC_END) / 64);
          m_phase = m_phase + 24'(m_inc);
        end
        sb.push_back(model_sample(m_env, m_phase[23]));
      end
      m_pending = (m_pending && !audio_clk_en) || (walk_en && !m_walk);
      m_walk = walk_en;
    end
  end

  task automatic check(input string tag, input int observed, input int expected);
    n_checks++;
    assert (observed === expected) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // One strobe, compare the produced sample, then verify it holds until the next strobe.
  task automatic do_sample(input string tag, output logic signed [15:0] got);
    logic signed [15:0] exp_v;
    @(negedge clk) audio_clk_en = 1'b1;
    @(negedge clk) audio_clk_en = 1'b0;
    got = out;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 1, 0);
      exp_v = '0;
    end else begin
      exp_v = sb.pop_front();
      check(tag, int'(got), int'(exp_v));
    end
    repeat (GAP - 2) @(negedge clk);
    check({tag, "_hold"}, int'(out), int'(exp_v));
  endtask

  task automatic run_samples(input string tag, input int n);
    logic signed [15:0] s;
    for (int i = 0; i < n; i++) do_sample(tag, s);
  endtask

  initial begin
    logic signed [15:0] s;
    int first_neg;
    first_neg = -1;

    // Reset and idle silence
    repeat (3) @(negedge clk);
    check("reset_out", int'(out), 0);
    reset = 1'b0;
    run_samples("idle", 10);

    // Trigger and long decay with walk_en held high
    @(negedge clk) walk_en = 1'b1;
    do_sample("trig_first", s);
    check("trig_first_value", int'(s), 16383);
    for (int i = 2; i <= 4000; i++) begin
      do_sample("decay", s);
      if (first_neg < 0 && s < 0) first_neg = i;
    end
    check("first_half_period_ok", int'(first_neg >= 25 && first_neg <= 50), 1);
    check("decay_residual_ok", int'(s <= 512 && s >= -512), 1);

    // Falling edge alone, then retrigger
    @(negedge clk) walk_en = 1'b0;
    run_samples("fall", 20);
    @(negedge clk) walk_en = 1'b1;
    do_sample("retrig", s);
    check("retrig_value", int'(s), 16383);
    run_samples("retrig_run", 100);

    // One-clock pulse between strobes
    @(negedge clk) walk_en = 1'b0;
    run_samples("pre_pulse", 5);
    @(negedge clk) walk_en = 1'b1;
    @(negedge clk) walk_en = 1'b0;
    do_sample("pulse", s);
    check("pulse_value", int'(s), 16383);
    run_samples("post_pulse", 10);

    // k consecutive strobe cycles produce k updates
    @(negedge clk) audio_clk_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 2) audio_clk_en = 1'b0;
      if (sb.size() == 0) check("burst_sb_empty", 1, 0);
      else check("burst", int'(out), int'(sb.pop_front()));
    end

    // Several edges with no strobe merge into one trigger
    run_samples("pre_merge", 40);
    @(negedge clk) walk_en = 1'b1;
    @(negedge clk) walk_en = 1'b0;
    @(negedge clk) walk_en = 1'b1;
    @(negedge clk) walk_en = 1'b0;
    do_sample("merge", s);
    check("merge_value", int'(s), 16383);
    run_samples("post_merge", 5);

    // Reset mid-sound silences immediately and stays silent until a new edge
    @(negedge clk) walk_en = 1'b1;
    run_samples("pre_reset", 50);
    @(negedge clk);
    walk_en = 1'b0;
    reset = 1'b1;
    #1;
    check("midreset_out", int'(out), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    run_samples("post_reset", 10);
    check("post_reset_silent", int'(out), 0);
    @(negedge clk) walk_en = 1'b1;
    do_sample("after_reset_trig", s);
    check("after_reset_trig_value", int'(s), 16383);

    check("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
